max_serial_receiver: RTL and testbench

- Receive-side model of the MAX7219 3-wire serial interface (DIN/CLK/LOAD).
- Captures 16-bit register-write frames and holds the 8 digit registers plus the control registers.
- Inverse-decodes the 8-bit segment patterns back to decimal digits 0-8.
- Sits on the display side of the enigma display path: in-system display mirroring/readback, and the scoreboard front end for display-driver verification.

---
 rtl/max_serial_receiver.sv | 176 +++++++++++++++++
 tb/tb_max_serial_receiver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_serial_receiver.sv
// MAX7219-style 3-wire serial receiver: captures 16-bit frames and mirrors the display registers.
// Optional Code-B digit decoding is enabled with the macro MAX_CODEB_DECODE_EN.
module max_serial_receiver #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        max_din,
    input  logic        max_clk,
    input  logic        max_load,
    output logic [63:0] digit_seg,
    output logic [31:0] digit_dec,
    output logic [7:0]  digit_dec_valid,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        display_test,
    output logic        frame_strobe,
    output logic        frame_error
);

    logic [SYNC_STAGES-1:0] din_sync_q, clk_sync_q, load_sync_q;
    logic                   clk_prev_q, load_prev_q;
    logic                   din_s, clk_s, load_s, clk_rise, load_rise;

    logic [15:0] shift_q, shift_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] seg_q, seg_d;
    logic [31:0] dec_q, dec_d;
    logic [7:0]  val_q, val_d;
    logic [7:0]  dm_q, dm_d;
    logic [3:0]  int_q, int_d;
    logic [2:0]  sl_q, sl_d;
    logic        sd_q, sd_d, dt_q, dt_d;
    logic        strobe_q, strobe_d, err_q, err_d;

    logic [3:0]  addr;
    logic [7:0]  data;
    logic [2:0]  k;
    logic [4:0]  dec_entry;
    logic        unused_hi;

    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign clk_s     = clk_sync_q[SYNC_STAGES-1];
    assign load_s    = load_sync_q[SYNC_STAGES-1];
    assign clk_rise  = clk_s & ~clk_prev_q;
    assign load_rise = load_s & ~load_prev_q;

    assign addr      = shift_q[11:8];
    assign data      = shift_q[7:0];
    assign k         = 3'(addr - 4'd1);
    assign unused_hi = ^shift_q[15:12];

    // Returns {valid, value}; only exact 7-segment glyphs with DP clear are recognised.
    function automatic logic [4:0] seg_inverse(input logic [7:0] b);
        unique case (b)
            8'h7E:   return {1'b1, 4'd0};
            8'h30:   return {1'b1, 4'd1};
            8'h6D:   return {1'b1, 4'd2};
            8'h79:   return {1'b1, 4'd3};
            8'h33:   return {1'b1, 4'd4};
            8'h5B:   return {1'b1, 4'd5};
            8'h5F:   return {1'b1, 4'd6};
            8'h70:   return {1'b1, 4'd7};
            8'h7F:   return {1'b1, 4'd8};
            default: return {1'b0, 4'hF};
        endcase
    endfunction

    always_comb begin
`ifdef MAX_CODEB_DECODE_EN
        if (dm_q[k]) begin
            dec_entry = (data[3:0] <= 4'd9) ? {1'b1, data[3:0]} : {1'b0, 4'hF};
        end else begin
            dec_entry = seg_inverse(data);
        end
`else
        dec_entry = seg_inverse(data);
`endif
    end

    always_comb begin
        shift_d  = shift_q;
        count_d  = count_q;
        seg_d    = seg_q;
        dec_d    = dec_q;
        val_d    = val_q;
        dm_d     = dm_q;
        int_d    = int_q;
        sl_d     = sl_q;
        sd_d     = sd_q;
        dt_d     = dt_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        // A LOAD rise takes priority over a coincident serial clock rise.
        if (load_rise) begin
            count_d = '0;
            if (count_q == 5'd16) begin
                strobe_d = 1'b1;
                unique case (addr)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                        seg_d[{k, 3'b000} +: 8] = data;
                        dec_d[{k, 2'b00} +: 4]  = dec_entry[3:0];
                        val_d[k]                = dec_entry[4];
                    end
                    4'h9:    dm_d = data;
                    4'hA:    int_d = data[3:0];
                    4'hB:    sl_d = data[2:0];
                    4'hC:    sd_d = data[0];
                    4'hF:    dt_d = data[0];
                    default: ;
                endcase
            end else begin
                err_d = 1'b1;
            end
        end else if (clk_rise && !load_s) begin
            shift_d = {shift_q[14:0], din_s};
            if (count_q != 5'd16) begin
                count_d = count_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            din_sync_q  <= '0;
            clk_sync_q  <= '0;
            load_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            load_prev_q <= 1'b0;
            shift_q     <= '0;
            count_q     <= '0;
            seg_q       <= '0;
            dec_q       <= {8{4'hF}};
            val_q       <= '0;
            dm_q        <= '0;
            int_q       <= '0;
            sl_q        <= '0;
            sd_q        <= 1'b0;
            dt_q        <= 1'b0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], max_din};
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], max_clk};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], max_load};
            clk_prev_q  <= clk_s;
            load_prev_q <= load_s;
            shift_q     <= shift_d;
            count_q     <= count_d;
            seg_q       <= seg_d;
            dec_q       <= dec_d;
            val_q       <= val_d;
            dm_q        <= dm_d;
            int_q       <= int_d;
            sl_q        <= sl_d;
            sd_q        <= sd_d;
            dt_q        <= dt_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
        end
    end

    assign digit_seg       = seg_q;
    assign digit_dec       = dec_q;
    assign digit_dec_valid = val_q;
    assign decode_mode     = dm_q;
    assign intensity       = int_q;
    assign scan_limit      = sl_q;
    assign shutdown_n      = sd_q;
    assign display_test    = dt_q;
    assign frame_strobe    = strobe_q;
    assign frame_error     = err_q;

endmodule

// File: tb/tb_max_serial_receiver.sv
// Self-checking bench for max_serial_receiver: vector table, directed corner cases, random frames.
module tb_max_serial_receiver;

    logic        clock = 1'b0;
    logic        reset, max_din, max_clk, max_load;
    logic [63:0] digit_seg;
    logic [31:0] digit_dec;
    logic [7:0]  digit_dec_valid, decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n, display_test, frame_strobe, frame_error;

    max_serial_receiver #(.SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .max_din(max_din), .max_clk(max_clk),
        .max_load(max_load), .digit_seg(digit_seg), .digit_dec(digit_dec),
        .digit_dec_valid(digit_dec_valid), .decode_mode(decode_mode),
        .intensity(intensity), .scan_limit(scan_limit), .shutdown_n(shutdown_n),
        .display_test(display_test), .frame_strobe(frame_strobe), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    localparam logic [7:0] Pats [9] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33,
                                        8'h5B, 8'h5F, 8'h70, 8'h7F};

    // Behavioural model: register file plus the list of bits seen since the last LOAD.
    logic [7:0] m_seg [8];
    logic [3:0] m_dec [8];
    logic       m_val [8];
    logic [7:0] m_dm;
    logic [3:0] m_int;
    logic [2:0] m_sl;
    logic       m_sd, m_dt;
    logic       q_bits [$];

    typedef struct {
        logic [31:0] bits;
        int          n;
        int          exp_strobe;
        int          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_seg[i] = 8'h00; m_dec[i] = 4'hF; m_val[i] = 1'b0;
        end
        m_dm = 0; m_int = 0; m_sl = 0; m_sd = 0; m_dt = 0;
        q_bits.delete();
    endtask

    task automatic model_decode(input logic [7:0] b, input logic dm,
                                output logic [3:0] d, output logic v);
        d = 4'hF; v = 1'b0;
        for (int i = 0; i < 9; i++) if (b == Pats[i]) begin d = 4'(i); v = 1'b1; end
`ifdef MAX_CODEB_DECODE_EN
        if (dm) begin
            v = (b[3:0] <= 4'd9);
            d = v ? b[3:0] : 4'hF;
        end
`else
        if (dm) d = d; // decode_mode has no effect in this build
`endif
    endtask

    task automatic model_commit(output int s, output int e);
        logic [15:0] f = 16'h0;
        int n = q_bits.size();
        int idx;
        s = 0; e = 0;
        if (n >= 16) begin
            s = 1;
            for (int i = n - 16; i < n; i++) f = {f[14:0], q_bits[i]};
            if (f[11:8] >= 4'h1 && f[11:8] <= 4'h8) begin
                idx = int'(f[11:8]) - 1;
                m_seg[idx] = f[7:0];
                model_decode(f[7:0], m_dm[idx], m_dec[idx], m_val[idx]);
            end else if (f[11:8] == 4'h9) m_dm = f[7:0];
            else if (f[11:8] == 4'hA) m_int = f[3:0];
            else if (f[11:8] == 4'hB) m_sl = f[2:0];
            else if (f[11:8] == 4'hC) m_sd = f[0];
            else if (f[11:8] == 4'hF) m_dt = f[0];
        end else begin
            e = 1;
        end
        q_bits.delete();
    endtask

    task automatic check_state(input string tag);
        logic [63:0] es;
        logic [31:0] ed;
        logic [7:0]  ev;
        for (int i = 0; i < 8; i++) begin
            es[8*i +: 8] = m_seg[i]; ed[4*i +: 4] = m_dec[i]; ev[i] = m_val[i];
        end
        chk({tag, " digit_seg"}, digit_seg, es);
        chk({tag, " digit_dec"}, 64'(digit_dec), 64'(ed));
        chk({tag, " digit_dec_valid"}, 64'(digit_dec_valid), 64'(ev));
        chk({tag, " ctrl"}, 64'({decode_mode, intensity, scan_limit, shutdown_n, display_test}),
            64'({m_dm, m_int, m_sl, m_sd, m_dt}));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            max_din = w[i];
            cyc(4);
            max_clk = 1'b1;
            cyc(4);
            max_clk = 1'b0;
            q_bits.push_back(w[i]);
        end
    endtask

    // Raises LOAD (optionally with a coincident max_clk rise), counts pulses, checks vs model.
    task automatic do_load(input string tag, input bit with_clk, input int toggles,
                           output int ns, output int ne);
        int s, e;
        ns = 0; ne = 0;
        cyc(1);
        max_load = 1'b1;
        if (with_clk) begin max_din = 1'b1; max_clk = 1'b1; end
        repeat (8) begin
            @(negedge clock);
            if (frame_strobe === 1'b1) ns++;
            if (frame_error === 1'b1) ne++;
        end
        cyc(1);
        max_clk = 1'b0;
        for (int t = 0; t < toggles; t++) begin
            cyc(4); max_clk = 1'b1; cyc(4); max_clk = 1'b0;
        end
        cyc(4);
        max_load = 1'b0;
        cyc(4);
        model_commit(s, e);
        chk({tag, " strobe pulses"}, 64'(ns), 64'(s));
        chk({tag, " error pulses"}, 64'(ne), 64'(e));
        @(negedge clock);
        check_state(tag);
    endtask

    vec_t vecs [12];

    initial begin
        int ns, ne;
        logic [15:0] f;
        int n;

        vecs[0]  = '{32'h0379,  16, 1, 0};
        vecs[1]  = '{32'h0880,  16, 1, 0};
        vecs[2]  = '{32'h03FF,  10, 0, 1};
        vecs[3]  = '{32'h0A07,  16, 1, 0};
        vecs[4]  = '{32'hA0C01, 20, 1, 0};
        vecs[5]  = '{32'h0B05,  16, 1, 0};
        vecs[6]  = '{32'h0005,  16, 1, 0};
        vecs[7]  = '{32'h0D55,  16, 1, 0};
        vecs[8]  = '{32'h0F01,  16, 1, 0};
        vecs[9]  = '{32'hF17E,  16, 1, 0};
        vecs[10] = '{32'h0,      0, 0, 1};
        vecs[11] = '{32'h0600,  16, 1, 0};

        reset = 1'b1; max_din = 0; max_clk = 0; max_load = 0;
        model_reset();
        cyc(3);
        @(negedge clock);
        chk("reset digit_seg", digit_seg, 64'h0);
        chk("reset digit_dec", 64'(digit_dec), 64'hFFFF_FFFF);
        chk("reset valid+ctrl", 64'({digit_dec_valid, decode_mode, intensity, scan_limit,
            shutdown_n, display_test, frame_strobe, frame_error}), 64'h0);
        cyc(1);
        reset = 1'b0;
        cyc(2);

        for (int i = 0; i < 12; i++) begin
            send_bits(vecs[i].bits, vecs[i].n);
            do_load($sformatf("vec%0d", i), 1'b0, 0, ns, ne);
            chk($sformatf("vec%0d table strobe", i), 64'(ns), 64'(vecs[i].exp_strobe));
            chk($sformatf("vec%0d table error", i), 64'(ne), 64'(vecs[i].exp_err));
        end

        chk("digit2 seg", 64'(digit_seg[23:16]), 64'h79);
        chk("digit2 dec", 64'(digit_dec[11:8]), 64'd3);
        chk("digit2 valid", 64'(digit_dec_valid[2]), 64'd1);
        chk("digit7 seg DP", 64'(digit_seg[63:56]), 64'h80);
        chk("digit7 dec DP", 64'(digit_dec[31:28]), 64'hF);
        chk("digit7 valid DP", 64'(digit_dec_valid[7]), 64'd0);
        chk("intensity", 64'(intensity), 64'd7);
        chk("shutdown_n last16", 64'(shutdown_n), 64'd1);
        chk("digit0 upper nibble ignored", 64'(digit_dec[3:0]), 64'd0);

        send_bits(32'h0901, 16); do_load("dm", 1'b0, 0, ns, ne);
        send_bits(32'h0106, 16); do_load("codeb6", 1'b0, 0, ns, ne);
        chk("codeb6 seg raw", 64'(digit_seg[7:0]), 64'h06);
`ifdef MAX_CODEB_DECODE_EN
        chk("codeb6 dec", 64'({digit_dec_valid[0], digit_dec[3:0]}), 64'h16);
`else
        chk("codeb6 dec", 64'({digit_dec_valid[0], digit_dec[3:0]}), 64'h0F);
`endif
        send_bits(32'h010B, 16); do_load("codebB", 1'b0, 0, ns, ne);
        chk("codebB dec", 64'({digit_dec_valid[0], digit_dec[3:0]}), 64'h0F);

        // Serial clocks while LOAD is high must not count toward the next frame.
        send_bits(32'h0B03, 16); do_load("clk_in_load", 1'b0, 3, ns, ne);
        send_bits(32'h3FFF, 14); do_load("after_clk_in_load", 1'b0, 0, ns, ne);
        chk("14 bits -> error", 64'(ne), 64'd1);

        // Coincident clock and LOAD rise: commit, no extra bit counted.
        send_bits(32'h0433, 16); do_load("simul", 1'b1, 0, ns, ne);
        chk("simul strobe", 64'(ns), 64'd1);
        chk("simul digit3", 64'(digit_dec[15:12]), 64'd4);
        send_bits(32'h7FFF, 15); do_load("simul_next15", 1'b0, 0, ns, ne);
        chk("15 bits after simul -> error", 64'(ne), 64'd1);

        // Reset mid-frame discards the partial frame.
        send_bits(32'hFF, 8);
        cyc(1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("midreset digit_dec", 64'(digit_dec), 64'hFFFF_FFFF);
        check_state("midreset");
        cyc(2);
        reset = 1'b0;
        cyc(2);
        do_load("first_load_after_reset", 1'b0, 0, ns, ne);
        chk("first load after reset error", 64'(ne), 64'd1);
        send_bits(32'h0230, 16); do_load("post_reset", 1'b0, 0, ns, ne);
        chk("post_reset digit1", 64'(digit_dec[7:4]), 64'd1);

        for (int r = 0; r < 30; r++) begin
            f[15:12] = 4'($urandom);
            f[11:8]  = 4'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                f[7:0] = Pats[$urandom_range(0, 8)];
                if ($urandom_range(0, 7) == 0) f[7] = 1'b1;
            end else begin
                f[7:0] = 8'($urandom);
            end
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 15)) :
                ($urandom_range(0, 7) == 0) ? 20 : 16;
            send_bits({12'($urandom), 4'h0, f}, n);
            do_load($sformatf("rand%0d", r), 1'b0, 0, ns, ne);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
